// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
// The arbiter uses the master view; the requester side and the decoder use the slave view.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, normal release and forced release.
// Produces a registered grant index for the downstream one-hot decoder.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4_if.master bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r;
  logic [1:0] last_idx_r;
  logic [7:0] hold_cnt_r;
  logic [1:0] gnt_idx_r;
  logic       gnt_valid_r;
  logic       timeout_r;
  logic [1:0] pick_s;

  // First requester after last_v in circular order; the nearest candidate wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
    logic [1:0] idx_v;
    rr_pick = last_v;
    for (int k = 4; k >= 1; k--) begin
      idx_v = last_v + 2'(k);
      if (req_v[idx_v]) begin
        rr_pick = idx_v;
      end
    end
  endfunction

  // Round-robin candidate for the next grant.
  always_comb begin
    pick_s = rr_pick(bus.req, last_idx_r);
  end

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_idx_r  <= 2'd3;
      hold_cnt_r  <= 8'd0;
      gnt_idx_r   <= 2'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req != 4'd0) begin
            gnt_idx_r   <= pick_s;
            gnt_valid_r <= 1'b1;
            hold_cnt_r  <= 8'd0;
            state_r     <= GRANT;
          end
        end
        GRANT: begin
          // gnt_idx_r is deliberately left intact on release.
          if (bus.done || !bus.req[gnt_idx_r]) begin
            last_idx_r  <= gnt_idx_r;
            gnt_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else if (hold_cnt_r == HOLD_LAST) begin
            last_idx_r  <= gnt_idx_r;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b1;
            state_r     <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_4;
  localparam int MH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // Reference model: who owns the resource, for how many cycles, and who went last.
  bit   m_valid;
  int   m_idx;
  bit   m_to;
  int   m_last;
  int   m_age;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input bit rn, input logic [3:0] r, input bit d);
    if (!rn) begin
      m_valid = 0; m_idx = 0; m_to = 0; m_last = 3; m_age = 0;
    end else if (!m_valid) begin
      m_to = 0;
      if (r != 4'd0) begin
        for (int k = 4; k >= 1; k--) begin
          if (r[(m_last + k) % 4]) m_idx = (m_last + k) % 4;
        end
        m_valid = 1;
        m_age = 1;
      end
    end else begin
      m_to = 0;
      if (d || !r[m_idx]) begin
        m_last = m_idx; m_valid = 0;
      end else if (m_age == MH) begin
        m_last = m_idx; m_valid = 0; m_to = 1;
      end else begin
        m_age = m_age + 1;
      end
    end
  endfunction

  task automatic tick(input bit rn, input logic [3:0] r, input bit d);
    rst_n = rn;
    bus.req = r;
    bus.done = d;
    @(posedge clk);
    model_step(rn, r, d);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 7; i++) begin
      tick((i >= 2) ? 1'b1 : 1'b0, 4'd0, 1'b0);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== 4'b0000) begin
        fails++;
        $display("FAIL reset cyc%0d: got v=%b i=%0d t=%b, want v=0 i=0 t=0",
                 i, bus.gnt_valid, bus.gnt_idx, bus.timeout);
      end
    end
  endtask

  task automatic test_single;
    bit dseq [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    tick(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'b0100, dseq[i]);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== {m_valid, 2'(m_idx), m_to}) begin
        fails++;
        $display("FAIL single cyc%0d: got v=%b i=%0d t=%b, want v=%b i=%0d t=%b",
                 i, bus.gnt_valid, bus.gnt_idx, bus.timeout, m_valid, m_idx, m_to);
      end
    end
    // Sequence: valid 3 cycles, idle 1, then re-granted to 2 (cycle index 4).
    tests++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd2) begin
      fails++;
      $display("FAIL single_regrant: got v=%b i=%0d, want v=1 i=2", bus.gnt_valid, bus.gnt_idx);
    end
  endtask

  task automatic test_rotation;
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    int n = 0;
    tick(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 4'b1111, 1'b1);
      tests++;
      if (bus.gnt_valid !== ((i % 2) == 0)) begin
        fails++;
        $display("FAIL rotation_valid cyc%0d: got %b, want %b", i, bus.gnt_valid, (i % 2) == 0);
      end
      if (bus.gnt_valid === 1'b1 && n < 6) begin
        tests++;
        if (int'(bus.gnt_idx) != exp_seq[n]) begin
          fails++;
          $display("FAIL rotation_idx grant%0d: got %0d, want %0d", n, bus.gnt_idx, exp_seq[n]);
        end
        n++;
      end
    end
  endtask

  task automatic test_timeout;
    tick(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 4'b0010, 1'b0);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== {m_valid, 2'(m_idx), m_to}) begin
        fails++;
        $display("FAIL timeout cyc%0d: got v=%b i=%0d t=%b, want v=%b i=%0d t=%b",
                 i, bus.gnt_valid, bus.gnt_idx, bus.timeout, m_valid, m_idx, m_to);
      end
    end
    // Cycles 0..3 granted, cycle 4 is the timeout pulse, cycle 5 re-grants.
  endtask

  task automatic test_simultaneous;
    bit dseq [6] = '{0, 0, 0, 0, 1, 0};
    logic [3:0] rseq [5] = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100};
    tick(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 4'b0010, dseq[i]);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== {m_valid, 2'(m_idx), m_to}) begin
        fails++;
        $display("FAIL done_at_limit cyc%0d: got v=%b i=%0d t=%b, want v=%b i=%0d t=%b",
                 i, bus.gnt_valid, bus.gnt_idx, bus.timeout, m_valid, m_idx, m_to);
      end
    end
    tick(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, rseq[i], 1'b0);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== {m_valid, 2'(m_idx), m_to}) begin
        fails++;
        $display("FAIL drop_req cyc%0d: got v=%b i=%0d t=%b, want v=%b i=%0d t=%b",
                 i, bus.gnt_valid, bus.gnt_idx, bus.timeout, m_valid, m_idx, m_to);
      end
    end
    tests++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd2) begin
      fails++;
      $display("FAIL drop_req_next: got v=%b i=%0d, want v=1 i=2", bus.gnt_valid, bus.gnt_idx);
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b0, 4'd0, 1'b0);
    tick(1'b1, 4'b1000, 1'b0);
    tick(1'b1, 4'b1000, 1'b0);
    tests++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd3) begin
      fails++;
      $display("FAIL reset_mid_grant: got v=%b i=%0d, want v=1 i=3", bus.gnt_valid, bus.gnt_idx);
    end
    tick(1'b0, 4'b1000, 1'b0);
    tests++;
    if ({bus.gnt_valid, bus.timeout} !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_clear: got v=%b t=%b, want v=0 t=0", bus.gnt_valid, bus.timeout);
    end
    tick(1'b1, 4'b1001, 1'b0);
    tests++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid_regrant: got v=%b i=%0d, want v=1 i=0", bus.gnt_valid, bus.gnt_idx);
    end
  endtask

  task automatic test_random;
    logic [3:0] r;
    bit d;
    bit rn;
    tick(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      r  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 49) != 0);
      tick(rn, r, d);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== {m_valid, 2'(m_idx), m_to}) begin
        fails++;
        $display("FAIL random cyc%0d: got v=%b i=%0d t=%b, want v=%b i=%0d t=%b",
                 i, bus.gnt_valid, bus.gnt_idx, bus.timeout, m_valid, m_idx, m_to);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req = 4'd0;
    bus.done = 1'b0;
    model_step(1'b0, 4'd0, 1'b0);
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that produces the registered 2-bit grant index `gnt_idx` consumed directly by the 2-to-4 one-hot decoder stage downstream (`gnt_idx` → decoder input `A`). It owns fairness, grant hold, and forced release on overrun. The decoder's one-hot output is only meaningful while `gnt_valid` is high.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held. Legal range 1..255. Hold counter is 8 bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  request vector; bit i means requester i wants the resource.
- `done`  in  1  current owner has finished; sampled only while `gnt_valid`=1.
- `gnt_idx`  out  2  index of the granted requester; registered.
- `gnt_valid`  out  1  grant active; registered.
- `timeout`  out  1  one-cycle pulse marking a forced release.

## Operation
- Reset (`rst_n`=0 at an edge): `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, `last_idx`=3, `hold_cnt`=0, state IDLE. The first arbitration after reset therefore favours requester 0.
- States: IDLE, GRANT.
- IDLE:
  - If `req`==0, remain in IDLE.
  - Otherwise select the first set bit scanning `last_idx+1`, `last_idx+2`, … modulo 4.
  - Register the selection in `gnt_idx`, set `gnt_valid`=1, clear `hold_cnt`, and go to GRANT.
- GRANT: each cycle, evaluate release conditions in priority order:
  1. `done`=1: normal release, `timeout` stays 0.
  2. `req[gnt_idx]`=0 (owner dropped its request): normal release, `timeout` stays 0.
  3. `hold_cnt`==`MAX_HOLD`-1: forced release, `timeout`=1 in the next cycle.
  4. None of the above: `hold_cnt`++ and stay in GRANT.
- On any release:
  - `last_idx`←`gnt_idx`, `gnt_valid`←0, state←IDLE.
  - `gnt_idx` keeps its value; it is not cleared. Consumers must qualify it with `gnt_valid`.
- `timeout` is 0 in every cycle except the single cycle after a forced release.
- `req` bits other than the owner's are ignored during GRANT. There is no preemption.
- `done` received in IDLE is ignored.

## Timing
- Grant latency: `req` is sampled at the edge ending cycle N, and `gnt_valid`=1 with a valid `gnt_idx` in cycle N+1.
- Release latency: a release condition in cycle M drives `gnt_valid`=0 in cycle M+1.
- Turnaround: there is exactly one dead cycle (IDLE) between consecutive grants, so the next grant appears at M+2 at the earliest.
- Grant duration: if the owner holds `req` and never asserts `done`, `gnt_valid` stays high for exactly `MAX_HOLD` cycles. `MAX_HOLD`=1 gives one-cycle grants.
- Simultaneous events: `done`=1 in the same cycle as `hold_cnt`==`MAX_HOLD`-1 is a normal release with no `timeout` pulse.
- Reset mid-grant: `rst_n`=0 at any edge overrides everything. In the next cycle `gnt_valid`=0, `timeout`=0, `last_idx`=3, and no partial grant survives.
- Wrap-around: `last_idx`=3 makes the scan order 0,1,2,3.
- Fairness bound: any requester holding `req` high is granted within 4 arbitration rounds.

## Test plan
- Reset/idle: hold `rst_n`=0 for 2 cycles, then release with `req`=0 for 5 cycles → `gnt_valid`=0, `gnt_idx`=0, `timeout`=0 throughout.
- Single requester: apply `req`=4'b0100 after reset and pulse `done` in the 3rd grant cycle → `gnt_idx`=2 and `gnt_valid`=1 in the cycle after `req` rises, high for 3 cycles, low 1 cycle, then re-granted to 2.
- Rotation: hold `req`=4'b1111 and pulse `done` in every grant cycle → `gnt_idx` sequence 0,1,2,3,0,1, each grant one cycle, separated by one idle cycle.
- Timeout: `MAX_HOLD`=4, `req`=4'b0010 held, `done` never asserted → `gnt_valid` high exactly 4 cycles, then `timeout`=1 for one cycle with `gnt_valid`=0, then grant to 1 again.
- Simultaneous done/timeout: `MAX_HOLD`=4, assert `done` in the 4th grant cycle → release with `timeout`=0. Separately, drop `req[owner]` in the 2nd grant cycle → release, `timeout`=0, next grant goes to the next requester in order.
- Reset mid-grant: `req`=4'b1000 granted, then `rst_n`=0 in the 2nd grant cycle → next cycle `gnt_valid`=0. After `rst_n`=1 with `req`=4'b1001 → `gnt_idx`=0, because `last_idx` was restored to 3.
